alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered execute/writeback boundary directly downstream of the 32-bit ALU.
//  Captures the ALU result, its C/Z/O/S flags and the destination register tag.
//  Buffers them in a 2-entry FIFO with a valid/ready handshake toward writeback.
//  Maintains the architectural condition-code register (CCR) and a sticky overflow bit.
// PARAMETERS
//  DWIDTH   32  data width; matches ALU result width
//  RADDR     5  destination register tag width
//  DEPTH     2  FIFO entries; legal values are 2 only
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       ALU result and flags present this cycle
//  in_ready     out  1       stage can accept (FIFO not full)
//  in_result    in   DWIDTH  ALU result
//  in_c/z/o/s   in   1 each  ALU carry/zero/overflow/sign flags
//  in_rd        in   RADDR   destination register tag
//  in_flag_upd  in   4       per-flag CCR update mask {C,Z,O,S}, from decode
//  out_valid    out  1       head entry valid
//  out_ready    in   1       writeback accepts head entry
//  out_result   out  DWIDTH  head result
//  out_rd       out  RADDR   head tag
//  out_flags    out  4       head flags {C,Z,O,S}
//  ccr          out  4       committed condition codes {C,Z,O,S}
//  ovf_sticky   out  1       set by any committed O=1 with O masked in; cleared by clr_sticky
//  clr_sticky   in   1       clears ovf_sticky
// BEHAVIOUR
//  - Reset, when rst=1 at a clk edge: FIFO empty; out_valid=0; in_ready=1.
//    out_result=0, out_rd=0, out_flags=0, ccr=4'b0000, ovf_sticky=0.
//  - Input accept = in_valid & in_ready. Output pop = out_valid & out_ready.
//  - in_ready = (count < DEPTH). It is registered-count-based and does not depend
//    on out_ready in the same cycle, so there is no comb path from out_ready to in_ready.
//  - Latency: an entry accepted at edge N is visible at the outputs after edge N
//    (out_valid=1 in cycle N+1). Minimum latency is 1 cycle.
//  - FIFO order is strict; no reordering and no dropping of entries.
//  - Head outputs are held stable while out_valid=1 and out_ready=0.
//  - Simultaneous accept and pop:
//    - count is unchanged;
//    - when full, accept is blocked because in_ready=0 that cycle;
//    - when count=1, the new entry becomes the head on the next cycle.
//  - Pointers are 1-bit read/write indices that wrap mod 2. count is 0..2.
//  - Commit happens on pop. For each bit k with the entry's stored flag_upd[k]=1,
//    ccr[k] <= head flag[k]. Masked-out bits keep their value.
//  - Sticky overflow on pop: if flag_upd[O]=1 and head O=1, then ovf_sticky <= 1.
//  - clr_sticky on the same edge as an overflow commit: set wins, ovf_sticky=1.
//  - When out_valid=0, out_* hold their last values. Bench checks them only when out_valid=1.
//  - Reset mid-operation: all in-flight entries are discarded and ccr is cleared.
//    No pop is recognised on the reset edge.
//  - Data and flags are stored verbatim; no width changes or arithmetic on data.
//  - Illegal push (in_valid=1, in_ready=0): ignored, and the upstream must hold its values.
// TESTING
//  1. Reset, idle: after rst pulse, in_ready=1, out_valid=0, ccr=0000, ovf_sticky=0.
//  2. Single pass: push result=32'h0000_0005, rd=3, flags C0 Z0 O0 S0, upd=1111,
//     out_ready=1. Expect out_valid next cycle with 5/3; ccr=0000 after pop.
//  3. Backpressure and fill:
//     - out_ready=0; push A=32'hFFFF_FFFF (S=1), then B=0 (Z=1).
//     - Expect in_ready=0 after 2 accepts; a third push is ignored.
//     - Release out_ready: A then B pop in order; ccr ends 0100 (Z only).
//  4. Mask: ccr=1000; push C=0, Z=1, upd=0100 -> after pop ccr=1100 (C retained).
//  5. Overflow sticky: push O=1, upd=0010 -> ovf_sticky=1 after pop.
//     Assert clr_sticky on that same pop edge -> stays 1. clr next cycle -> 0.
//  6. Reset mid-flight: 2 entries queued, rst=1 for one edge -> out_valid=0,
//     in_ready=1, ccr=0000; next push behaves as in test 2.

Source files
------------

// File: rtl/alu_result_stage.sv
// ============================================================================
//  Module      : alu_result_stage
//  Description : Execute/writeback boundary. Buffers ALU results, flags and
//                destination tags in a 2-entry FIFO and commits the condition
//                codes (CCR) and sticky overflow bit when writeback pops an entry.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
    parameter int DWIDTH = 32,
    parameter int RADDR  = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_result,
    input  logic              in_c,
    input  logic              in_z,
    input  logic              in_o,
    input  logic              in_s,
    input  logic [RADDR-1:0]  in_rd,
    input  logic [3:0]        in_flag_upd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_result,
    output logic [RADDR-1:0]  out_rd,
    output logic [3:0]        out_flags,
    output logic [3:0]        ccr,
    output logic              ovf_sticky,
    input  logic              clr_sticky
);

    localparam logic [1:0] c_DEPTH  = 2'(DEPTH);
    localparam int         c_FLAG_O = 1;

    logic [DWIDTH-1:0] r_mem_result_q [2];
    logic [DWIDTH-1:0] w_mem_result_d [2];
    logic [RADDR-1:0]  r_mem_rd_q     [2];
    logic [RADDR-1:0]  w_mem_rd_d     [2];
    logic [3:0]        r_mem_flags_q  [2];
    logic [3:0]        w_mem_flags_d  [2];
    logic [3:0]        r_mem_upd_q    [2];
    logic [3:0]        w_mem_upd_d    [2];

    logic       r_wr_ptr_q, w_wr_ptr_d;
    logic       r_rd_ptr_q, w_rd_ptr_d;
    logic [1:0] r_count_q,  w_count_d;
    logic [3:0] r_ccr_q,    w_ccr_d;
    logic       r_sticky_q, w_sticky_d;

    logic       w_accept;
    logic       w_pop;
    logic       w_out_sel;
    logic [3:0] w_head_flags;
    logic [3:0] w_head_upd;

    assign in_ready  = (r_count_q < c_DEPTH);
    assign out_valid = (r_count_q != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // When empty, the read pointer has already moved past the last popped
    // slot, which is left untouched until refilled, so selecting the other
    // slot holds the previous head values on the outputs.
    assign w_out_sel    = out_valid ? r_rd_ptr_q : ~r_rd_ptr_q;
    assign out_result   = r_mem_result_q[w_out_sel];
    assign out_rd       = r_mem_rd_q[w_out_sel];
    assign out_flags    = r_mem_flags_q[w_out_sel];
    assign w_head_flags = r_mem_flags_q[r_rd_ptr_q];
    assign w_head_upd   = r_mem_upd_q[r_rd_ptr_q];
    assign ccr          = r_ccr_q;
    assign ovf_sticky   = r_sticky_q;

    always_comb begin
        w_mem_result_d = r_mem_result_q;
        w_mem_rd_d     = r_mem_rd_q;
        w_mem_flags_d  = r_mem_flags_q;
        w_mem_upd_d    = r_mem_upd_q;
        w_wr_ptr_d     = r_wr_ptr_q;
        w_rd_ptr_d     = r_rd_ptr_q;
        w_count_d      = r_count_q;
        w_ccr_d        = r_ccr_q;
        w_sticky_d     = r_sticky_q;

        if (w_accept) begin
            w_mem_result_d[r_wr_ptr_q] = in_result;
            w_mem_rd_d[r_wr_ptr_q]     = in_rd;
            w_mem_flags_d[r_wr_ptr_q]  = {in_c, in_z, in_o, in_s};
            w_mem_upd_d[r_wr_ptr_q]    = in_flag_upd;
            w_wr_ptr_d                 = ~r_wr_ptr_q;
        end

        if (clr_sticky) begin
            w_sticky_d = 1'b0;
        end

        if (w_pop) begin
            w_rd_ptr_d = ~r_rd_ptr_q;
            w_ccr_d    = (r_ccr_q & ~w_head_upd) | (w_head_flags & w_head_upd);
            // An overflow commit overrides a simultaneous clear.
            if (w_head_upd[c_FLAG_O] && w_head_flags[c_FLAG_O]) begin
                w_sticky_d = 1'b1;
            end
        end

        case ({w_accept, w_pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_result_q[i] <= '0;
                r_mem_rd_q[i]     <= '0;
                r_mem_flags_q[i]  <= '0;
                r_mem_upd_q[i]    <= '0;
            end
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
            r_count_q  <= 2'd0;
            r_ccr_q    <= 4'b0000;
            r_sticky_q <= 1'b0;
        end else begin
            r_mem_result_q <= w_mem_result_d;
            r_mem_rd_q     <= w_mem_rd_d;
            r_mem_flags_q  <= w_mem_flags_d;
            r_mem_upd_q    <= w_mem_upd_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_count_q      <= w_count_d;
            r_ccr_q        <= w_ccr_d;
            r_sticky_q     <= w_sticky_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Directed-vector bench for alu_result_stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_c, in_z, in_o, in_s;
    logic [4:0]  in_rd;
    logic [3:0]  in_flag_upd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [3:0]  out_flags;
    logic [3:0]  ccr;
    logic        ovf_sticky;
    logic        clr_sticky;

    int n_vec = 0;
    int n_err = 0;

    alu_result_stage #(.DWIDTH(32), .RADDR(5), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_c        (in_c),
        .in_z        (in_z),
        .in_o        (in_o),
        .in_s        (in_s),
        .in_rd       (in_rd),
        .in_flag_upd (in_flag_upd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_flags   (out_flags),
        .ccr         (ccr),
        .ovf_sticky  (ovf_sticky),
        .clr_sticky  (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic [3:0] flags, input logic [3:0] upd);
        in_valid    = v;
        in_result   = res;
        in_rd       = rd;
        {in_c, in_z, in_o, in_s} = flags;
        in_flag_upd = upd;
    endtask

    initial begin
        rst = 1'b1;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        step();
        step();
        rst = 1'b0;

        // 1. reset / idle
        check_val("rst_in_ready",   32'(in_ready),   32'd1);
        check_val("rst_out_valid",  32'(out_valid),  32'd0);
        check_val("rst_ccr",        32'(ccr),        32'd0);
        check_val("rst_sticky",     32'(ovf_sticky), 32'd0);
        check_val("rst_out_result", out_result,      32'd0);
        check_val("rst_out_rd",     32'(out_rd),     32'd0);
        check_val("rst_out_flags",  32'(out_flags),  32'd0);

        // 2. single pass
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 5'd3, 4'b0000, 4'b1111);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        check_val("t2_out_valid",  32'(out_valid), 32'd1);
        check_val("t2_out_result", out_result,     32'h5);
        check_val("t2_out_rd",     32'(out_rd),    32'd3);
        step();
        check_val("t2_empty",      32'(out_valid), 32'd0);
        check_val("t2_ccr",        32'(ccr),       32'd0);

        // 3. backpressure and fill
        out_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 5'd1, 4'b0001, 4'b1111);
        step();
        check_val("t3_ready_1",  32'(in_ready),  32'd1);
        check_val("t3_head_A",   out_result,     32'hFFFF_FFFF);
        drive(1'b1, 32'h0000_0000, 5'd2, 4'b0100, 4'b1111);
        step();
        check_val("t3_full",     32'(in_ready),  32'd0);
        drive(1'b1, 32'h0000_1234, 5'd7, 4'b1111, 4'b1111);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        check_val("t3_still_full", 32'(in_ready), 32'd0);
        check_val("t3_hold_A",     out_result,    32'hFFFF_FFFF);
        check_val("t3_hold_A_rd",  32'(out_rd),   32'd1);
        check_val("t3_hold_A_fl",  32'(out_flags), 32'b0001);
        check_val("t3_ccr_nopop",  32'(ccr),      32'd0);
        out_ready = 1'b1;
        step();
        check_val("t3_B_valid",  32'(out_valid), 32'd1);
        check_val("t3_B_result", out_result,     32'h0);
        check_val("t3_B_rd",     32'(out_rd),    32'd2);
        check_val("t3_B_flags",  32'(out_flags), 32'b0100);
        check_val("t3_ccr_A",    32'(ccr),       32'b0001);
        step();
        check_val("t3_empty",    32'(out_valid), 32'd0);
        check_val("t3_ccr_B",    32'(ccr),       32'b0100);

        // 4. mask, with back-to-back push so accept and pop coincide at count=1
        drive(1'b1, 32'h0000_0011, 5'd4, 4'b1000, 4'b1111);
        step();
        drive(1'b1, 32'h0000_0022, 5'd5, 4'b0100, 4'b0100);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        check_val("t4_head_new",  out_result,     32'h22);
        check_val("t4_head_rd",   32'(out_rd),    32'd5);
        check_val("t4_valid",     32'(out_valid), 32'd1);
        check_val("t4_ccr_C",     32'(ccr),       32'b1000);
        step();
        check_val("t4_ccr_mask",  32'(ccr),       32'b1100);
        check_val("t4_empty",     32'(out_valid), 32'd0);

        // 5. overflow sticky; masked-out O first must not set it
        drive(1'b1, 32'h0000_0033, 5'd6, 4'b0010, 4'b0000);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        step();
        check_val("t5_masked_o",  32'(ovf_sticky), 32'd0);
        check_val("t5_ccr_keep",  32'(ccr),        32'b1100);
        drive(1'b1, 32'h0000_0044, 5'd6, 4'b0010, 4'b0010);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        clr_sticky = 1'b1;
        step();
        check_val("t5_set_wins",  32'(ovf_sticky), 32'd1);
        check_val("t5_ccr_O",     32'(ccr),        32'b1110);
        step();
        clr_sticky = 1'b0;
        check_val("t5_cleared",   32'(ovf_sticky), 32'd0);

        // 6. reset mid-flight, with out_ready high on the reset edge
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_00AA, 5'd8, 4'b1111, 4'b1111);
        step();
        drive(1'b1, 32'h0000_00BB, 5'd9, 4'b1111, 4'b1111);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        check_val("t6_full",      32'(in_ready),  32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        check_val("t6_out_valid", 32'(out_valid),  32'd0);
        check_val("t6_in_ready",  32'(in_ready),   32'd1);
        check_val("t6_ccr",       32'(ccr),        32'd0);
        check_val("t6_sticky",    32'(ovf_sticky), 32'd0);
        drive(1'b1, 32'h0000_0005, 5'd3, 4'b0000, 4'b1111);
        step();
        drive(1'b0, 32'h0, 5'd0, 4'b0000, 4'b0000);
        check_val("t6_out_result", out_result,     32'h5);
        check_val("t6_out_rd",     32'(out_rd),    32'd3);
        step();
        check_val("t6_empty",      32'(out_valid), 32'd0);
        check_val("t6_ccr_end",    32'(ccr),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
